// File: rtl/snow64_seq_count_zeros_pkg.sv
// Shared types for the sequential leading/trailing zero counter.
// Optional feature macro: SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN.
package PkgSnow64SeqCountZeros;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_t;

  typedef enum logic {
    ModeClz = 1'b0,
    ModeCtz = 1'b1
  } mode_t;

endpackage

// File: rtl/snow64_seq_count_zeros_chunk_clz.sv
// Combinational leading-zero count of one chunk.
// An all-zero chunk yields WIDTH__CHUNK.
module snow64_chunk_clz #(
  parameter int WIDTH__CHUNK = 16
) (
  input  logic [WIDTH__CHUNK-1:0]         in_chunk,
  output logic [$clog2(WIDTH__CHUNK):0]   out_clz
);

  localparam int CW = $clog2(WIDTH__CHUNK) + 1;

  logic w_found;

  // Priority search from the MSB for the first set bit.
  always_comb begin
    out_clz = CW'(WIDTH__CHUNK);
    w_found = 1'b0;
    for (int i = WIDTH__CHUNK - 1; i >= 0; i--) begin
      if (!w_found && in_chunk[i]) begin
        out_clz = CW'(WIDTH__CHUNK - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snow64_seq_count_zeros.sv
// Sequential CLZ/CTZ counter, one chunk scanned per cycle.
// Define SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN to stop at the first nonzero chunk.
module snow64_seq_count_zeros
  import PkgSnow64SeqCountZeros::*;
#(
  parameter int WIDTH__DATA_IN = 64,
  parameter int WIDTH__CHUNK   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_start,
  input  logic [WIDTH__DATA_IN-1:0]         in_data,
  input  logic                              in_mode,
  output logic                              out_ready,
  output logic                              out_valid,
  output logic [$clog2(WIDTH__DATA_IN):0]   out_count
);

  localparam int N    = WIDTH__DATA_IN / WIDTH__CHUNK;
  localparam int CNTW = $clog2(WIDTH__DATA_IN) + 1;
  localparam int KW   = $clog2(N) + 1;
  localparam int CCW  = $clog2(WIDTH__CHUNK) + 1;

  state_t                    r_state;
  logic [WIDTH__DATA_IN-1:0] r_data;
  logic [KW-1:0]             r_k;
  logic                      r_valid;
  logic [CNTW-1:0]           r_count;
`ifndef SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN
  logic                      r_found;
  logic [CNTW-1:0]           r_first;
`endif

  logic [WIDTH__DATA_IN-1:0] w_rev;
  logic [WIDTH__DATA_IN-1:0] w_sh;
  logic [WIDTH__CHUNK-1:0]   w_chunk;
  logic [CCW-1:0]            w_clz;
  logic [CNTW-1:0]           w_res;
  logic                      w_nz;
  logic                      w_last;

  // CTZ is done as CLZ of the bit-reversed operand.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < WIDTH__DATA_IN; i++) begin
      w_rev[i] = in_data[WIDTH__DATA_IN-1-i];
    end
  end

  assign w_sh    = r_data << (int'(r_k) * WIDTH__CHUNK);
  assign w_chunk = w_sh[WIDTH__DATA_IN-1 -: WIDTH__CHUNK];
  assign w_nz    = |w_chunk;
  assign w_last  = (r_k == KW'(N - 1));
  assign w_res   = CNTW'(int'(r_k) * WIDTH__CHUNK)
                 + CNTW'(w_clz);

  snow64_chunk_clz #(
    .WIDTH__CHUNK(WIDTH__CHUNK)
  ) u_chunk_clz (
    .in_chunk(w_chunk),
    .out_clz (w_clz)
  );

  assign out_ready = (r_state == StIdle);
  assign out_valid = r_valid;
  assign out_count = r_count;

  // Idle -> Scan -> Done -> Idle control with registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
`ifndef SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN
      r_found <= 1'b0;
      r_first <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_valid <= 1'b0;
          if (in_start) begin
            r_data  <= (mode_t'(in_mode) == ModeCtz) ? w_rev : in_data;
            r_k     <= '0;
            r_state <= StScan;
`ifndef SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN
            r_found <= 1'b0;
`endif
          end
        end
        StScan: begin
`ifdef SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN
          if (w_nz || w_last) begin
            r_count <= w_nz ? w_res : CNTW'(WIDTH__DATA_IN);
            r_valid <= 1'b1;
            r_state <= StDone;
          end else begin
            r_k <= r_k + 1'b1;
          end
`else
          if (w_nz && !r_found) begin
            r_first <= w_res;
            r_found <= 1'b1;
          end
          if (w_last) begin
            if (r_found)   r_count <= r_first;
            else if (w_nz) r_count <= w_res;
            else           r_count <= CNTW'(WIDTH__DATA_IN);
            r_valid <= 1'b1;
            r_state <= StDone;
          end else begin
            r_k <= r_k + 1'b1;
          end
`endif
        end
        StDone: begin
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_seq_count_zeros.sv
// Directed scoreboard bench for snow64_seq_count_zeros.
// Latency expectations follow SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN.
module tb_snow64_seq_count_zeros;

  localparam int W  = 64;
  localparam int C  = 16;
  localparam int N  = W / C;

  typedef struct {
    int    cnt;
    int    lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start;
  logic [63:0] in_data;
  logic        in_mode;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  out_count;

  logic [15:0] t_chunk;
  logic [4:0]  t_clz;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  snow64_seq_count_zeros #(
    .WIDTH__DATA_IN(W),
    .WIDTH__CHUNK  (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_start (in_start),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_count(out_count)
  );

  snow64_chunk_clz #(
    .WIDTH__CHUNK(C)
  ) u_clz (
    .in_chunk(t_chunk),
    .out_clz (t_clz)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_clz(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) if (d[i]) return 63 - i;
    return 64;
  endfunction

  function automatic int ref_ctz(input logic [63:0] d);
    for (int i = 0; i < 64; i++) if (d[i]) return i;
    return 64;
  endfunction

  function automatic int ref_clz16(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) if (d[i]) return 15 - i;
    return 16;
  endfunction

  function automatic int lat_of(input int cnt);
    int k;
    k = (cnt >= W) ? N - 1 : cnt / C;
`ifdef SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN
    return k + 1;
`else
    return N;
`endif
  endfunction

  task automatic run_op(input logic [63:0] d, input logic m,
                        input bit poke, input string tag);
    exp_t e;
    exp_t g;
    bit   got;
    e.cnt = m ? ref_ctz(d) : ref_clz(d);
    e.lat = lat_of(e.cnt);
    q.push_back(e);
    @(negedge clk);
    check({tag, "_rdy"}, int'(out_ready), 1);
    in_start = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_data  = '0;
    in_mode  = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      if (poke && c == 1) begin
        in_start = 1'b1;
        in_data  = 64'h1;
      end
      check({tag, "_busy"}, int'(out_ready), 0);
      @(posedge clk);
      #1;
      in_start = 1'b0;
      in_data  = '0;
      if (out_valid) begin
        got = 1'b1;
        if (q.size() == 0) begin
          check({tag, "_qempty"}, 0, 1);
        end else begin
          g = q.pop_front();
          check({tag, "_cnt"}, int'(out_count), g.cnt);
          check({tag, "_lat"}, c, g.lat);
        end
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      void'(q.pop_front());
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_nopulse"}, int'(out_valid), 0);
      check({tag, "_hold"}, int'(out_count), e.cnt);
    end
    check({tag, "_idle"}, int'(out_ready), 1);
  endtask

  initial begin
    rst      = 1'b1;
    in_start = 1'b0;
    in_data  = '0;
    in_mode  = 1'b0;
    t_chunk  = '0;
    #1;
    check("rst_ready", int'(out_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(out_count), 0);

    for (int i = 0; i < 65536; i++) begin
      t_chunk = i[15:0];
      #1;
      check("chunk_clz", int'(t_clz), ref_clz16(t_chunk));
    end

    @(negedge clk);
    rst = 1'b0;

    run_op(64'h8000_0000_0000_0000, 1'b0, 1'b0, "clz_msb");
    run_op(64'h0000_0000_0001_0000, 1'b0, 1'b0, "clz_47");
    run_op(64'h0,                   1'b0, 1'b0, "clz_zero");
    run_op(64'h0,                   1'b1, 1'b0, "ctz_zero");
    run_op(64'h0000_0000_0000_0100, 1'b1, 1'b0, "ctz_8");
    run_op(64'h0000_0000_0000_0001, 1'b0, 1'b0, "clz_lsb");
    run_op(64'h8000_0000_0000_0000, 1'b1, 1'b0, "ctz_msb");
    run_op(64'h0000_8000_0000_0000, 1'b0, 1'b0, "clz_16");
    run_op(64'h0000_0000_0000_0000, 1'b0, 1'b1, "poke_zero");
    run_op(64'h0000_0000_0001_0000, 1'b0, 1'b1, "poke_47");
    for (int r = 0; r < 6; r++) begin
      logic [63:0] d;
      d = {$urandom(), $urandom()} >> $urandom_range(63, 0);
      run_op(d, r[0], 1'b0, "rand");
    end

    @(negedge clk);
    in_start = 1'b1;
    in_data  = 64'h0;
    in_mode  = 1'b0;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_count", int'(out_count), 0);
    check("mid_rst_ready", int'(out_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_nopulse", int'(out_valid), 0);
    end
    run_op(64'h1, 1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snow64_seq_count_zeros.md
SNOW64_SEQ_COUNT_ZEROS -- requirements
Module: snow64_seq_count_zeros

Interface
REQ-001 SHALL have parameter WIDTH__DATA_IN, default 64, meaning operand width in bits; power of two, at least 16.
REQ-002 SHALL have parameter WIDTH__CHUNK, default 16, meaning bits examined per scan cycle; power of two, divides WIDTH__DATA_IN.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port in_start, input, 1 bit, meaning request a count.
REQ-006 SHALL have port in_data, input, WIDTH__DATA_IN bits, meaning the operand.
REQ-007 SHALL have port in_mode, input, 1 bit, meaning 0 = count leading zeros (CLZ), 1 = count trailing zeros (CTZ).
REQ-008 SHALL have port out_ready, output, 1 bit, meaning the block can accept in_start.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_count holds a result.
REQ-010 SHALL have port out_count, output, clog2(WIDTH__DATA_IN)+1 bits, meaning the zero count.

Function
REQ-011 SHALL run an FSM with states Idle, Scan and Done; out_ready SHALL equal (state == Idle).
REQ-012 SHALL, in Idle with in_start=1 at a clock edge, latch the operand (in_data in CLZ mode, bit-reversed in_data in CTZ mode), set chunk index k=0 and enter Scan.
REQ-013 SHALL ignore in_start while in Scan or Done; no state, data or output change results.
REQ-014 SHALL, at each Scan edge, evaluate latched chunk k, counted from the MSB end of the latched operand.
REQ-015 SHALL, when chunk k is nonzero, register out_count = k*WIDTH__CHUNK + (leading zeros of chunk k) and enter Done.
REQ-016 SHALL, when all chunks are zero, register out_count = WIDTH__DATA_IN after the last chunk and enter Done.
REQ-017 SHALL hold out_valid high for exactly the one cycle spent in Done; Done SHALL return to Idle unconditionally at the next edge.
REQ-018 SHALL assert out_valid k+1 edges after the accepting edge, where k is the index of the first nonzero chunk, or N-1 when all chunks are zero (N = WIDTH__DATA_IN/WIDTH__CHUNK).
REQ-019 SHALL hold out_count stable until the next result is registered.
REQ-020 SHALL keep the chunk index wide enough that it never wraps before N-1.

Reset
REQ-021 SHALL, while rst=1 (including mid-Scan), force state=Idle, out_valid=0, out_count=0, k=0 and latched data=0; out_ready is then 1.
REQ-022 SHALL produce no out_valid pulse for an operation aborted by reset.

Configuration
REQ-023 SHALL use macro SNOW64_SEQ_COUNT_ZEROS_EARLY_EXIT_EN.
REQ-024 SHALL, with the macro defined, terminate Scan at the first nonzero chunk, per REQ-015 and REQ-018.
REQ-025 SHALL, with the macro undefined, always scan all N chunks, remember the first nonzero chunk's result, and assert out_valid exactly N edges after the accepting edge; the counts SHALL be identical to the macro-defined build.

Structure
REQ-026 SHALL place the FSM state enum and the mode enum (ModeClz=0, ModeCtz=1) in shared package PkgSnow64SeqCountZeros.
REQ-027 SHALL instantiate one combinational sub-module, snow64_chunk_clz (parameter WIDTH__CHUNK), which returns WIDTH__CHUNK for an all-zero chunk.

Verification
REQ-028 SHALL cover, with defaults and macro defined: CLZ of 0x8000_0000_0000_0000 -> out_count 0, out_valid 1 edge after accept; CLZ of 0x0000_0000_0001_0000 -> 47, out_valid 3 edges after accept.
REQ-029 SHALL cover: CLZ and CTZ of 0 -> 64, out_valid 4 edges after accept; CTZ of 0x0000_0000_0000_0100 -> 8, out_valid 1 edge after accept.
REQ-030 SHALL cover: in_start with in_data=0x1 pulsed during Scan of a first operation -> ignored, exactly one out_valid pulse carrying the first result, out_ready 0 throughout.
REQ-031 SHALL cover: rst asserted mid-Scan -> same-cycle out_valid=0, out_count=0, out_ready=1; no later pulse; a fresh CLZ of 0x1 afterwards -> 63.
REQ-032 SHALL cover, with macro undefined: CLZ of 0x8000_0000_0000_0000 -> 0, out_valid exactly 4 edges after accept.
REQ-033 SHALL exhaustively check snow64_chunk_clz over all 2^16 inputs against a loop oracle, with input 0 -> 16.
